// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset and system reset release from a synchronized lock flag.
// Counts lock timeouts and lock losses in saturating counters.
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RST_HOLD_CYCLES    = 64,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int CNT_W              = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             locked,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [CNT_W-1:0] relock_cnt
);
   localparam int CMAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES)
                         ? ((PLL_RST_CYCLES > RST_HOLD_CYCLES) ? PLL_RST_CYCLES : RST_HOLD_CYCLES)
                         : ((LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES);
   localparam int CW = $clog2(CMAX + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   typedef enum logic [1:0] {PLLRST, WAIT, HOLD, RUN} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cyc, cyc_n;
   logic [TW-1:0] to, to_n;
   logic          lock_meta, locked_s, to_ev, rl_ev;
   always_comb begin
      state_n = state;
      cyc_n   = cyc + CW'(1);
      to_n    = (state == WAIT) ? to + TW'(1) : '0;
      to_ev   = 1'b0;
      rl_ev   = 1'b0;
      case (state)
         PLLRST: if (cyc == CW'(PLL_RST_CYCLES - 1)) state_n = WAIT;
         WAIT: begin
            if (!locked_s) cyc_n = '0;
            else if (cyc == CW'(LOCK_STABLE_CYCLES - 1)) state_n = HOLD;
            // stable completion takes priority over a coincident timeout
            if (state_n == WAIT && to == TW'(LOCK_TIMEOUT - 1)) begin
               state_n = PLLRST;
               to_ev   = 1'b1;
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_n = WAIT;
               rl_ev   = 1'b1;
            end else if (cyc == CW'(RST_HOLD_CYCLES - 1)) state_n = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_n = WAIT;
               rl_ev   = 1'b1;
            end
         end
         default: state_n = PLLRST;
      endcase
      if (state_n != state) cyc_n = '0;
   end
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_meta   <= 1'b0;
         locked_s    <= 1'b0;
         state       <= PLLRST;
         cyc         <= '0;
         to          <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         timeout_cnt <= '0;
         relock_cnt  <= '0;
      end else begin
         lock_meta   <= locked;
         locked_s    <= lock_meta;
         state       <= state_n;
         cyc         <= cyc_n;
         to          <= to_n;
         pll_rst     <= state_n == PLLRST;
         sys_rst     <= state_n != RUN;
         ready       <= state_n == RUN;
         timeout_cnt <= timeout_cnt + CNT_W'(to_ev && !(&timeout_cnt));
         relock_cnt  <= relock_cnt + CNT_W'(rl_ev && !(&relock_cnt));
      end
   end
endmodule
